// File: rtl/rat_io_responder_if.sv
// RAT MCU port bus: address, write data and strobe from the MCU,
// read data back from the peripheral.
interface rat_io_responder_if;
    logic [7:0] PORT_ID;
    logic [7:0] OUT_PORT;
    logic       IO_STRB;
    logic [7:0] IN_PORT;

    modport master (
        output PORT_ID,
        output OUT_PORT,
        output IO_STRB,
        input  IN_PORT
    );

    modport slave (
        input  PORT_ID,
        input  OUT_PORT,
        input  IO_STRB,
        output IN_PORT
    );
endinterface

// File: rtl/rat_io_responder.sv
// Peripheral responder for the RAT MCU port bus: LED / seven-segment
// registers, synchronized switches, debounced buttons with latched
// press events and a masked level interrupt.
module rat_io_responder #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic                      CLK,
    input  logic                      RESET,
    rat_io_responder_if.slave         bus,
    input  logic [7:0]                SWITCHES,
    input  logic [3:0]                BUTTONS,
    output logic [7:0]                LEDS,
    output logic [7:0]                SSEG_VAL,
    output logic                      INT_CU
);
    localparam int unsigned DB_W = $clog2(DB_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    localparam logic [7:0] ADDR_SW     = 8'h20;
    localparam logic [7:0] ADDR_STATUS = 8'h24;
    localparam logic [7:0] ADDR_EVENT  = 8'h25;
    localparam logic [7:0] ADDR_MASK   = 8'h26;
    localparam logic [7:0] ADDR_LEDS   = 8'h40;
    localparam logic [7:0] ADDR_SSEG   = 8'h81;

    logic [7:0]      r_sw_s1, r_sw_s2;
    logic [3:0]      r_btn_s1, r_btn_s2;
    logic [DB_W-1:0] r_cnt [4];
    logic [3:0]      r_status;
    logic [3:0]      r_ev;
    logic [3:0]      r_mask;
    logic [7:0]      r_leds;
    logic [7:0]      r_sseg;
    logic            r_int;

    logic [3:0]      w_rise;
    logic [3:0]      w_clr;
    logic            w_wr_ev, w_wr_mask, w_wr_leds, w_wr_sseg;

    // Two-flop synchronizers for switches and buttons
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= SWITCHES;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= BUTTONS;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Per-button debounce: status follows sync only after DB_CYCLES stable cycles
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_status <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_btn_s2[i] == r_status[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_status[i] <= r_btn_s2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Press detection (status about to go 0->1) and write decode
    always_comb begin
        w_rise = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_rise[i] = ~r_status[i] & r_btn_s2[i] & (r_cnt[i] == DB_LAST);
        end
        w_wr_ev   = bus.IO_STRB && (bus.PORT_ID == ADDR_EVENT);
        w_wr_mask = bus.IO_STRB && (bus.PORT_ID == ADDR_MASK);
        w_wr_leds = bus.IO_STRB && (bus.PORT_ID == ADDR_LEDS);
        w_wr_sseg = bus.IO_STRB && (bus.PORT_ID == ADDR_SSEG);
        w_clr     = w_wr_ev ? bus.OUT_PORT[3:0] : '0;
    end

    // Writable registers, event latch (set wins over clear) and interrupt
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_leds <= '0;
            r_sseg <= '0;
            r_mask <= '0;
            r_ev   <= '0;
            r_int  <= 1'b0;
        end else begin
            if (w_wr_leds) r_leds <= bus.OUT_PORT;
            if (w_wr_sseg) r_sseg <= bus.OUT_PORT;
            if (w_wr_mask) r_mask <= bus.OUT_PORT[3:0];
            r_ev  <= (r_ev & ~w_clr) | w_rise;
            r_int <= |(r_ev & r_mask);
        end
    end

    // Zero-latency read mux of registered state
    always_comb begin
        case (bus.PORT_ID)
            ADDR_SW:     bus.IN_PORT = r_sw_s2;
            ADDR_STATUS: bus.IN_PORT = {4'b0000, r_status};
            ADDR_EVENT:  bus.IN_PORT = {4'b0000, r_ev};
            ADDR_MASK:   bus.IN_PORT = {4'b0000, r_mask};
            ADDR_LEDS:   bus.IN_PORT = r_leds;
            ADDR_SSEG:   bus.IN_PORT = r_sseg;
            default:     bus.IN_PORT = '0;
        endcase
    end

    assign LEDS     = r_leds;
    assign SSEG_VAL = r_sseg;
    assign INT_CU   = r_int;
endmodule
